// File: rtl/riscv_shift_seq.sv
// ----------------------------------------------------------------------------
// riscv_shift_seq
// Multi-cycle barrel-less shifter for a RISC-V core. This unit handles
// SLL/SRL/SRA and pass-through. It moves at most STEP bit positions per
// clock, so a 32-bit shift can complete without a full barrel shifter.
//
// Parameters
//   STEP    maximum bit positions shifted per cycle (1, 2, 4 or 8)
//
// Ports
//   clk     clock, rising edge
//   rst     asynchronous active-low reset
//   start   shift request, sampled only while idle
//   op      00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   a       operand (rs1)
//   shamt   shift amount (low 5 bits of rs2 / immediate)
//   kill    synchronous abort of the operation in flight
//   result  shifted value, valid with done and held until the next start
//   done    single-cycle completion pulse
//   busy    high while shifting or completing
//   stall   combinational hold request to PC / pipeline registers
// ----------------------------------------------------------------------------
module riscv_shift_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        kill,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        stall
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [4:0] STEP_C = 5'(STEP);

    logic [1:0]  state;
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [4:0]  step_amt;

    // One partial shift of up to STEP positions. SRA stays correct across
    // steps because an arithmetic shift never alters bit 31. The sign
    // captured at start is therefore replicated on every step.
    function automatic logic [31:0] shift_by(
        input logic [31:0] v,
        input logic [1:0]  sel,
        input logic [4:0]  s
    );
        logic signed [31:0] sv;
        sv = signed'(v);
        case (sel)
            OP_SLL:  shift_by = v << s;
            OP_SRL:  shift_by = v >> s;
            OP_SRA:  shift_by = unsigned'(sv >>> s);
            default: shift_by = v;
        endcase
    endfunction

    // min(STEP, cnt): the final step consumes only what remains, so cnt
    // reaches exactly zero and never wraps.
    always_comb begin
        step_amt = (cnt < STEP_C) ? cnt : STEP_C;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= OP_SLL;
        end else begin
            case (state)
                IDLE: begin
                    // A kill in the same cycle blocks acceptance.
                    if (start && !kill) begin
                        acc  <= a;
                        op_q <= op;
                        cnt  <= shamt;
                        state <= (shamt == 5'd0 || op == OP_PASS) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        acc <= shift_by(acc, op_q, step_amt);
                        cnt <= cnt - step_amt;
                        if (cnt <= STEP_C) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign result = acc;
    // A kill landing on the DONE cycle suppresses the completion pulse.
    assign done   = (state == DONE) && !kill;
    assign busy   = (state == SHIFT) || (state == DONE);
    // Low in DONE so the datapath advances in the cycle result is valid.
    assign stall  = ((state == IDLE) && start) || (state == SHIFT);

endmodule

// File: tb/tb_riscv_shift_seq.sv
module tb_riscv_shift_seq;

    logic        clk;
    logic        rst;
    logic        start_v  [2];
    logic [1:0]  op_v     [2];
    logic [31:0] a_v      [2];
    logic [4:0]  shamt_v  [2];
    logic        kill_v   [2];
    logic [31:0] result_v [2];
    logic        done_v   [2];
    logic        busy_v   [2];
    logic        stall_v  [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0 uses STEP=1 and instance 1 uses STEP=8.
    riscv_shift_seq #(.STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .a(a_v[0]),
        .shamt(shamt_v[0]), .kill(kill_v[0]), .result(result_v[0]),
        .done(done_v[0]), .busy(busy_v[0]), .stall(stall_v[0])
    );

    riscv_shift_seq #(.STEP(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .a(a_v[1]),
        .shamt(shamt_v[1]), .kill(kill_v[1]), .result(result_v[1]),
        .done(done_v[1]), .busy(busy_v[1]), .stall(stall_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d)", n_tests);
        $fatal(1, "watchdog");
    end

    // Reference model written directly from the ISA semantics.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] av,
                                              input logic [4:0] sh);
        logic [31:0] r;
        case (o)
            2'b00: r = av << sh;
            2'b01: r = av >> sh;
            2'b10: begin
                r = av;
                for (int i = 0; i < int'(sh); i++) r = {av[31], r[31:1]};
            end
            default: r = av;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [4:0] sh, input int step);
        if (o == 2'b11 || sh == 5'd0) return 1;
        return 1 + (int'(sh) + step - 1) / step;
    endfunction

    // One complete operation on DUT d, with an optional stray start pulse
    // during the first busy cycle that must be ignored.
    task automatic do_shift(input int d, input logic [1:0] o, input logic [31:0] av,
                            input logic [4:0] sh, input bit mid_start, input bit no_wait);
        logic [31:0] exp_r;
        int exp_lat;
        int edges;
        exp_r   = ref_shift(o, av, sh);
        exp_lat = ref_lat(o, sh, (d == 0) ? 1 : 8);
        if (!no_wait) @(negedge clk);
        start_v[d] = 1'b1; op_v[d] = o; a_v[d] = av; shamt_v[d] = sh;
        #1;
        n_tests++;
        if (stall_v[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_on_start d=%0d: got %b want 1", d, stall_v[d]);
        end
        @(negedge clk);
        start_v[d] = 1'b0;
        a_v[d] = $urandom; shamt_v[d] = 5'($urandom_range(0, 31)); op_v[d] = 2'($urandom_range(0, 3));
        edges = 1;
        while (done_v[d] !== 1'b1 && edges < 40) begin
            n_tests++;
            if (stall_v[d] !== 1'b1 || busy_v[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL shifting d=%0d edge=%0d: stall=%b busy=%b want 1 1",
                         d, edges, stall_v[d], busy_v[d]);
            end
            if (mid_start && edges == 1) begin
                start_v[d] = 1'b1; a_v[d] = 32'hFFFF_FFFF; op_v[d] = 2'b00; shamt_v[d] = 5'd0;
            end else begin
                start_v[d] = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start_v[d] = 1'b0;
        n_tests++;
        if (edges != exp_lat) begin
            n_fail++;
            $display("FAIL latency d=%0d op=%0d sh=%0d: got %0d want %0d", d, o, sh, edges, exp_lat);
        end
        n_tests++;
        if (result_v[d] !== exp_r) begin
            n_fail++;
            $display("FAIL result d=%0d op=%0d a=%h sh=%0d: got %h want %h",
                     d, o, av, sh, result_v[d], exp_r);
        end
        n_tests++;
        if (stall_v[d] !== 1'b0 || busy_v[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_cycle d=%0d: stall=%b busy=%b want 0 1", d, stall_v[d], busy_v[d]);
        end
        @(negedge clk);
        n_tests++;
        if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || result_v[d] !== exp_r) begin
            n_fail++;
            $display("FAIL after_done d=%0d: done=%b busy=%b result=%h want 0 0 %h",
                     d, done_v[d], busy_v[d], result_v[d], exp_r);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (result_v[d] !== 32'h0 || done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || stall_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state d=%0d: result=%h done=%b busy=%b stall=%b want 0",
                         d, result_v[d], done_v[d], busy_v[d], stall_v[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        do_shift(0, 2'b01, 32'h0000_00F0, 5'd4, 1'b0, 1'b0);
        do_shift(0, 2'b10, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        do_shift(0, 2'b01, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        do_shift(0, 2'b00, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
        do_shift(1, 2'b00, 32'h0000_0001, 5'd31, 1'b1, 1'b0);
        do_shift(1, 2'b11, 32'hDEAD_BEEF, 5'd17, 1'b0, 1'b0);
        do_shift(1, 2'b10, 32'h8765_4321, 5'd9, 1'b0, 1'b0);
    endtask

    task automatic test_kill();
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = 2'b01; a_v[0] = 32'hFFFF_0000; shamt_v[0] = 5'd10;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        kill_v[0] = 1'b1;
        #1;
        n_tests++;
        if (done_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_no_done: got %b want 0", done_v[0]);
        end
        @(negedge clk);
        kill_v[0] = 1'b0;
        n_tests++;
        if (busy_v[0] !== 1'b0 || stall_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle: busy=%b stall=%b done=%b want 0 0 0", busy_v[0], stall_v[0], done_v[0]);
        end
        do_shift(0, 2'b01, 32'h0000_0100, 5'd8, 1'b0, 1'b0);
        // A kill in IDLE blocks a start in the same cycle.
        @(negedge clk);
        start_v[1] = 1'b1; kill_v[1] = 1'b1; op_v[1] = 2'b00; a_v[1] = 32'h5; shamt_v[1] = 5'd3;
        @(negedge clk);
        start_v[1] = 1'b0; kill_v[1] = 1'b0;
        n_tests++;
        if (busy_v[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_blocks_start: busy=%b want 0", busy_v[1]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = 2'b11; a_v[0] = 32'hCAFE_F00D; shamt_v[0] = 5'd0;
        @(negedge clk);
        n_tests++;
        if (done_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_done: got %b want 1", done_v[0]);
        end
        start_v[0] = 1'b1; op_v[0] = 2'b01; a_v[0] = 32'h1111_1111; shamt_v[0] = 5'd3;
        @(negedge clk);
        start_v[0] = 1'b0;
        n_tests++;
        if (busy_v[0] !== 1'b0 || result_v[0] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL start_in_done: busy=%b result=%h want 0 cafef00d", busy_v[0], result_v[0]);
        end
        do_shift(0, 2'b00, 32'h0000_0003, 5'd2, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = 2'b10; a_v[0] = 32'h8000_1234; shamt_v[0] = 5'd20;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (result_v[0] !== 32'h0 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || stall_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: result=%h done=%b busy=%b stall=%b want 0",
                     result_v[0], done_v[0], busy_v[0], stall_v[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (done_v[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_done: got %b want 0", done_v[0]);
            end
        end
        rst = 1'b1;
        do_shift(0, 2'b00, 32'h0000_0001, 5'd1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            for (int d = 0; d < 2; d++) begin
                do_shift(d, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; op_v[d] = 2'b00; a_v[d] = 32'h0; shamt_v[d] = 5'd0; kill_v[d] = 1'b0;
        end
        test_reset();
        test_directed();
        test_kill();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_shift_seq.md
RISCV_SHIFT_SEQ -- requirements
Module: riscv_shift_seq

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning the maximum number of bit positions shifted per cycle; legal values are 1, 2, 4, 8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, meaning request a shift; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2, selecting the shift: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
REQ-006 SHALL have port a, input, 32, the operand (rs1 value).
REQ-007 SHALL have port shamt, input, 5, the shift amount; only the low 5 bits of rs2 or the immediate are used.
REQ-008 SHALL have port kill, input, 1, a synchronous abort of the operation in flight.
REQ-009 SHALL have port result, output, 32, the shifted value; valid while done=1 and held until the next accepted start.
REQ-010 SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1, high in states SHIFT and DONE.
REQ-012 SHALL have port stall, output, 1, the combinational stall request to the datapath PC and pipeline registers.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the rising edge SHALL capture a into acc, op into op_q and shamt into cnt.
REQ-015 On that same edge, the next state SHALL be DONE when shamt=0 or op=11; otherwise it SHALL be SHIFT.
REQ-016 In SHIFT, each edge SHALL shift acc by s=min(STEP,cnt) and set cnt=cnt-s.
REQ-017 In SHIFT, the FSM SHALL go to DONE on the edge where cnt<=STEP; otherwise it SHALL remain in SHIFT.
REQ-018 SLL SHALL fill with zeros from the LSB.
REQ-019 SRL SHALL fill with zeros from the MSB.
REQ-020 SRA SHALL replicate the bit a[31] captured at start.
REQ-021 Pass-through (op=11) SHALL give result=a unmodified.
REQ-022 Latency SHALL be 1+ceil(shamt/STEP) rising edges from the start-accepting edge to the first cycle with done=1; op=11 SHALL take 1 edge.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-024 A start asserted during the DONE cycle SHALL be ignored; the requester re-asserts it in IDLE.
REQ-025 start SHALL be ignored in SHIFT and DONE, with no change to acc, cnt or op_q.
REQ-026 stall SHALL equal (state==IDLE && start) || state==SHIFT, so it is low in the DONE cycle and the datapath advances exactly when result is valid.
REQ-027 result SHALL be driven from acc and SHALL hold its value in IDLE after DONE until the next accepted start.
REQ-028 kill=1 in SHIFT or DONE SHALL force IDLE on the next edge with done=0 that cycle; acc is don't-care afterwards.
REQ-029 kill SHALL take priority over start and over the SHIFT to DONE transition.
REQ-030 kill in IDLE SHALL block acceptance of a start asserted in the same cycle.
REQ-031 cnt SHALL be 5 bits wide and never underflow; shamt=31 with STEP=8 SHALL shift by 8, 8, 8, 7.

Reset
REQ-032 While rst=0, the block SHALL asynchronously force state=IDLE, acc=0, cnt=0, op_q=00, result=0, done=0, busy=0, stall=0.
REQ-033 Reset mid-operation SHALL discard the operation with no done pulse.
REQ-034 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-035 STEP=1, op=01, a=0x000000F0, shamt=4, start pulsed one cycle -> done on edge 5, result=0x0000000F, stall high for 5 cycles then low.
REQ-036 STEP=1, op=10, a=0x80000000, shamt=31 -> done on edge 32, result=0xFFFFFFFF; with op=01 -> result=0x00000001.
REQ-037 op=00, a=0x12345678, shamt=0 -> done after 1 edge, result=0x12345678, busy high exactly 1 cycle.
REQ-038 STEP=8, op=00, a=0x00000001, shamt=31 -> done on edge 5, result=0x80000000; a second start with a=0xFFFFFFFF pulsed mid-SHIFT -> ignored, result unchanged.
REQ-039 kill pulsed on edge 3 of an SRL by 10 -> IDLE next cycle, no done pulse; a following SRL of 0x100 by 8 -> result=0x00000001.
REQ-040 rst low on edge 2 of an SRA by 20 -> all outputs 0 immediately (asynchronously) and no done pulse; after release, SLL of 0x1 by 1 -> result=0x00000002.
